uart_tx_ctrl: RTL and testbench

//  RS232 transmitter; companion to the UART receive path.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_tx_ctrl.sv | 119 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-timing helpers and parity.
// Used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } uart_state_t;

  function automatic int bit_cycles(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int half_bit_cycles(input int clk_freq, input int baud_rate);
    return bit_cycles(clk_freq, baud_rate) / 2;
  endfunction

  // A one-cycle bit period still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic frame_parity(input logic [7:0] data, input int nbits,
                                        input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) p ^= data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period tick generator: counts 0..CYCLES-1 while enabled, pulses end_bit
// on the last count, and rests at zero when disabled or cleared.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CYCLES = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic end_bit
);

  localparam int W = cnt_width(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || !enable || end_bit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign end_bit = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: serialises one word into start/data/parity/stop bits.
// Outputs are registered from the next-state decode so tx never glitches.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t          state, state_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [2:0]           bit_cnt, bit_cnt_nxt;
  logic                 parity_bit, parity_nxt;
  logic                 tx_nxt, busy_nxt, done_nxt;
  logic                 accept, baud_en, end_bit;

  assign baud_en = (state == ST_START) || (state == ST_DATA) ||
                   (state == ST_PARITY) || (state == ST_STOP);

  uart_baud_tick #(.CYCLES(BIT_CYCLES)) baud (
    .clk     (clk),
    .rst     (rst),
    .enable  (baud_en),
    .clear   (accept),
    .end_bit (end_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift      <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      parity_bit <= parity_nxt;
      tx         <= tx_nxt;
      tx_busy    <= busy_nxt;
      tx_done    <= done_nxt;
    end
  end

  // bit_cnt counts data bits in DATA and is reused to count stop bits in STOP.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    parity_nxt  = parity_bit;
    accept      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_start) begin
          accept      = 1'b1;
          shift_nxt   = tx_data;
          parity_nxt  = frame_parity(8'(tx_data), DATA_BITS, PARITY_ODD != 0);
          bit_cnt_nxt = '0;
          state_nxt   = ST_START;
        end
      end
      ST_START: if (end_bit) state_nxt = ST_DATA;
      ST_DATA: begin
        if (end_bit) begin
          shift_nxt = shift >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_nxt = '0;
            state_nxt   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      ST_PARITY: if (end_bit) state_nxt = ST_STOP;
      ST_STOP: begin
        if (end_bit) begin
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_nxt = '0;
            state_nxt   = ST_DONE;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    tx_nxt = 1'b1;
    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shift_nxt[0];
      ST_PARITY: tx_nxt = parity_nxt;
      default:   tx_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_DONE);
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: four configurations, expected frames queued
// at accept time and compared bit by bit as the serial line produces them.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic [3:0] start_v;
  wire  [3:0] tx_v, busy_v, done_v;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int         acc_q[$];
  logic [7:0] data_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_ctrl #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_BITS(8),
                 .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_plain (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(start_v[0]),
    .tx_busy(busy_v[0]), .tx_done(done_v[0]), .tx(tx_v[0]));

  uart_tx_ctrl #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_BITS(8),
                 .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_even (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(start_v[1]),
    .tx_busy(busy_v[1]), .tx_done(done_v[1]), .tx(tx_v[1]));

  uart_tx_ctrl #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_BITS(8),
                 .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_odd (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(start_v[2]),
    .tx_busy(busy_v[2]), .tx_done(done_v[2]), .tx(tx_v[2]));

  uart_tx_ctrl #(.CLK_FREQ(460800), .BAUD_RATE(115200), .DATA_BITS(5),
                 .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_small (
    .clk(clk), .rst(rst), .tx_data(tx_data[4:0]), .tx_start(start_v[3]),
    .tx_busy(busy_v[3]), .tx_done(done_v[3]), .tx(tx_v[3]));

  function automatic int cfg_bc(input int idx);     return (idx == 3) ? 4 : 434; endfunction
  function automatic int cfg_dbits(input int idx);  return (idx == 3) ? 5 : 8;   endfunction
  function automatic int cfg_par_en(input int idx); return (idx == 1 || idx == 2) ? 1 : 0; endfunction
  function automatic int cfg_par_odd(input int idx); return (idx == 2) ? 1 : 0;  endfunction
  function automatic int cfg_stop(input int idx);   return (idx == 3) ? 2 : 1;   endfunction

  function automatic int frame_bits(input int idx);
    return 1 + cfg_dbits(idx) + cfg_par_en(idx) + cfg_stop(idx);
  endfunction

  function automatic logic exp_bit(input int idx, input logic [7:0] data, input int j);
    int db;
    logic p;
    db = cfg_dbits(idx);
    if (j == 0) return 1'b0;
    if (j <= db) return data[j-1];
    if (cfg_par_en(idx) != 0 && j == db + 1) begin
      p = (cfg_par_odd(idx) != 0);
      for (int k = 0; k < db; k++) p ^= data[k];
      return p;
    end
    return 1'b1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Called on a negedge; the following posedge is the accept edge.
  task automatic apply_stimulus(input int idx, input logic [7:0] data);
    tx_data = data;
    start_v[idx] = 1'b1;
    acc_q.push_back(cyc);
    data_q.push_back(data);
    @(negedge clk);
    start_v[idx] = 1'b0;
  endtask

  task automatic monitor_frames(input int idx, input int nframes);
    for (int f = 0; f < nframes; f++) begin
      int acc, bc, nb, db, done_at;
      logic [7:0] data, rx, mask;
      logic b;
      acc  = acc_q.pop_front();
      data = data_q.pop_front();
      bc = cfg_bc(idx);
      nb = frame_bits(idx);
      db = cfg_dbits(idx);
      done_at = acc + nb * bc + 1;
      mask = 8'((1 << db) - 1);
      rx = 8'h00;
      wait_cyc(acc + 1);
      check_output("start_latency", 32'(tx_v[idx]), 32'd0);
      check_output("busy_rise", 32'(busy_v[idx]), 32'd1);
      for (int j = 0; j < nb; j++) begin
        wait_cyc(acc + 1 + j * bc + bc / 2);
        b = tx_v[idx];
        check_output($sformatf("dut%0d_bit%0d", idx, j), 32'(b), 32'(exp_bit(idx, data, j)));
        if (j >= 1 && j <= db) rx[j-1] = b;
      end
      check_output("loopback", 32'(rx), 32'(data & mask));
      wait_cyc(done_at - 1);
      check_output("done_early", 32'(done_v[idx]), 32'd0);
      check_output("stop_level", 32'(tx_v[idx]), 32'd1);
      wait_cyc(done_at);
      check_output("done_pulse", 32'(done_v[idx]), 32'd1);
      check_output("busy_in_done", 32'(busy_v[idx]), 32'd1);
      wait_cyc(done_at + 1);
      check_output("done_width", 32'(done_v[idx]), 32'd0);
      check_output("busy_fall", 32'(busy_v[idx]), 32'd0);
      check_output("idle_high", 32'(tx_v[idx]), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a, nb;
    rst = 1'b0;
    tx_data = 8'h00;
    start_v = 4'h0;
    repeat (3) @(negedge clk);
    check_output("reset_tx", 32'(tx_v[0]), 32'd1);
    check_output("reset_busy", 32'(busy_v[0]), 32'd0);
    check_output("reset_done", 32'(done_v[0]), 32'd0);
    check_output("reset_tx_small", 32'(tx_v[3]), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame and loopback
    apply_stimulus(0, 8'hA5);
    monitor_frames(0, 1);

    // Even then odd parity
    apply_stimulus(1, 8'h07);
    monitor_frames(1, 1);
    apply_stimulus(2, 8'h07);
    monitor_frames(2, 1);

    // Mid-frame request with different data must be ignored
    a = cyc;
    apply_stimulus(0, 8'h96);
    fork
      monitor_frames(0, 1);
      begin
        wait_cyc(a + 2000);
        tx_data = 8'hFF;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    check_output("no_queue_busy", 32'(busy_v[0]), 32'd0);
    check_output("no_queue_tx", 32'(tx_v[0]), 32'd1);

    // Held start: back-to-back frames with one idle cycle between
    nb = frame_bits(0);
    a = cyc;
    tx_data = 8'h55;
    start_v[0] = 1'b1;
    acc_q.push_back(a);
    data_q.push_back(8'h55);
    acc_q.push_back(a + nb * 434 + 2);
    data_q.push_back(8'hAA);
    fork
      monitor_frames(0, 2);
      begin
        @(negedge clk);
        tx_data = 8'hAA;
        wait_cyc(a + nb * 434 + 3);
        start_v[0] = 1'b0;
      end
    join

    // Reset in the middle of a data bit aborts the frame
    @(negedge clk);
    a = cyc;
    tx_data = 8'h00;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_cyc(a + 1 + 4 * 434 + 217);
    check_output("pre_reset_tx", 32'(tx_v[0]), 32'd0);
    rst = 1'b0;
    #1;
    check_output("abort_tx", 32'(tx_v[0]), 32'd1);
    check_output("abort_busy", 32'(busy_v[0]), 32'd0);
    check_output("abort_done", 32'(done_v[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    apply_stimulus(0, 8'h3C);
    monitor_frames(0, 1);

    // Short configuration: 4 clocks per bit, 5 data bits, 2 stop bits
    apply_stimulus(3, 8'h16);
    monitor_frames(3, 1);
    apply_stimulus(3, 8'h0B);
    monitor_frames(3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
